// File: rtl/ldtu_pkg.sv
// Shared constants for the LiTe-DTU sample packer: word headers and packer state encoding.
package ldtu_pkg;

  localparam logic [1:0] HDR_BASE  = 2'b01;
  localparam logic [5:0] HDR_SIG   = 6'b001010;
  localparam logic [3:0] HDR_PBASE = 4'b1100;
  localparam logic [5:0] HDR_PSIG  = 6'b001011;
  localparam logic [3:0] HDR_FRAME = 4'b1110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BASE  = 2'd1,
    ST_SIG   = 2'd2
  } pk_state_e;

endpackage

// File: rtl/ldtu_word_fifo.sv
// Show-ahead 32-bit word FIFO; a second write port exists when LDTU_PACKER_FRAME_EN is defined.
module ldtu_word_fifo #(
  parameter int Depth = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push0,
  input  logic [31:0]             i_data0,
`ifdef LDTU_PACKER_FRAME_EN
  input  logic                    i_push1,
  input  logic [31:0]             i_data1,
  output logic                    o_acc0,
`endif
  input  logic                    i_pop,
  output logic [31:0]             o_data,
  output logic                    o_valid,
  output logic [$clog2(Depth):0]  o_level,
  output logic                    o_overflow
);
  localparam int AW = $clog2(Depth);

  logic [Depth-1:0][31:0] r_mem;
  logic [AW-1:0]          r_wr, r_rd;
  logic [AW:0]            r_level;
  logic                   r_ovf;
  logic                   w_pop, w_ok0, w_ok1, w_drop;
  logic [AW+1:0]          w_free;

  // A same-cycle pop frees a slot for the incoming write(s).
  assign w_pop  = i_pop && (r_level != '0);
  assign w_free = (AW+2)'(Depth) - (AW+2)'(r_level) + (AW+2)'(w_pop);
  assign w_ok0  = i_push0 && (w_free >= (AW+2)'(1));
`ifdef LDTU_PACKER_FRAME_EN
  assign w_ok1  = i_push1 && (w_free >= (AW+2)'(2));
  assign w_drop = (i_push0 && !w_ok0) || (i_push1 && !w_ok1);
  assign o_acc0 = w_ok0;
`else
  assign w_ok1  = 1'b0;
  assign w_drop = i_push0 && !w_ok0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_ok0) r_mem[r_wr] <= i_data0;
`ifdef LDTU_PACKER_FRAME_EN
      if (w_ok1) r_mem[r_wr + AW'(1)] <= i_data1;
`endif
      r_wr    <= r_wr + AW'(w_ok0) + AW'(w_ok1);
      r_rd    <= r_rd + AW'(w_pop);
      r_level <= r_level + (AW+1)'(w_ok0) + (AW+1)'(w_ok1) - (AW+1)'(w_pop);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage is not cleared on reset, so gate the head word while empty.
  assign o_data     = (r_level != '0) ? r_mem[r_rd] : 32'h0;
  assign o_valid    = (r_level != '0);
  assign o_level    = r_level;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/ldtu_sample_packer.sv
// Packs baseline (6b) and signal (13b) samples into 32-bit words for the serializer.
// Optional frame words are enabled by defining LDTU_PACKER_FRAME_EN.
module ldtu_sample_packer
  import ldtu_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int FrameLen  = 64
) (
  input  logic                        CLK_,
  input  logic                        reset_,
  input  logic                        sample_valid,
  input  logic [12:0]                 DATA_in,
  input  logic                        baseline_flag,
  input  logic                        word_ready,
  output logic [31:0]                 word_out,
  output logic                        word_valid,
  output logic [$clog2(FifoDepth):0]  fifo_level,
  output logic                        overflow
);
  pk_state_e        r_state;
  logic [2:0]       r_cnt;
  logic [3:0][5:0]  r_base;
  logic [12:0]      r_sig;
  logic [3:0][5:0]  w_slots;
  logic             w_push;
  logic [31:0]      w_word;

  if (FifoDepth < 4 || (FifoDepth & (FifoDepth - 1)) != 0 || FrameLen < 1) begin : g_bad_param
  end

  always_comb begin
    w_slots = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(r_cnt)) w_slots[i] = r_base[i];
  end

  always_comb begin
    w_push = 1'b0;
    w_word = 32'h0;
    if (sample_valid) begin
      case (r_state)
        ST_BASE: begin
          if (baseline_flag && r_cnt == 3'd4) begin
            w_push = 1'b1;
            w_word = {HDR_BASE, DATA_in[5:0], r_base[3], r_base[2], r_base[1], r_base[0]};
          end else if (!baseline_flag) begin
            w_push = 1'b1;
            w_word = {HDR_PBASE, r_cnt, 1'b0, w_slots};
          end
        end
        ST_SIG: begin
          w_push = 1'b1;
          w_word = baseline_flag ? {HDR_PSIG, 13'b0, r_sig} : {HDR_SIG, DATA_in, r_sig};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_) begin
    if (reset_) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_base  <= '0;
      r_sig   <= '0;
    end else if (sample_valid) begin
      if (baseline_flag) begin
        if (r_state == ST_BASE && r_cnt == 3'd4) begin
          r_state <= ST_EMPTY;
          r_cnt   <= '0;
        end else if (r_state == ST_BASE) begin
          r_base[r_cnt[1:0]] <= DATA_in[5:0];
          r_cnt              <= r_cnt + 3'd1;
        end else begin
          r_state   <= ST_BASE;
          r_base[0] <= DATA_in[5:0];
          r_cnt     <= 3'd1;
        end
      end else begin
        r_cnt   <= '0;
        r_state <= (r_state == ST_SIG) ? ST_EMPTY : ST_SIG;
        r_sig   <= DATA_in;
      end
    end
  end

`ifdef LDTU_PACKER_FRAME_EN
  localparam int FCW = $clog2(FrameLen) + 1;
  logic [FCW-1:0] r_dcnt;
  logic [7:0]     r_fcnt;
  logic           w_acc0, w_push1;
  logic [31:0]    w_word1;

  // Only data words that actually entered the FIFO count toward a frame.
  assign w_push1 = w_acc0 && (r_dcnt == FCW'(FrameLen - 1));
  assign w_word1 = {HDR_FRAME, 20'b0, r_fcnt};

  always_ff @(posedge CLK_) begin
    if (reset_) begin
      r_dcnt <= '0;
      r_fcnt <= '0;
    end else if (w_push1) begin
      r_dcnt <= '0;
      r_fcnt <= r_fcnt + 8'd1;
    end else if (w_acc0) begin
      r_dcnt <= r_dcnt + FCW'(1);
    end
  end
`endif

  ldtu_word_fifo #(.Depth(FifoDepth)) u_fifo (
    .i_clk      (CLK_),
    .i_rst      (reset_),
    .i_push0    (w_push),
    .i_data0    (w_word),
`ifdef LDTU_PACKER_FRAME_EN
    .i_push1    (w_push1),
    .i_data1    (w_word1),
    .o_acc0     (w_acc0),
`endif
    .i_pop      (word_ready),
    .o_data     (word_out),
    .o_valid    (word_valid),
    .o_level    (fifo_level),
    .o_overflow (overflow)
  );

endmodule
